// File: rtl/cpu7_csr_excp_pkg.sv
// rtl/cpu7_csr_excp_pkg.sv - CSR addresses, field positions and reset values
`timescale 1ns/10ps
package cpu7_csr_excp_pkg;

   localparam int CSR_CRMD   = 'h00;
   localparam int CSR_PRMD   = 'h01;
   localparam int CSR_ECFG   = 'h04;
   localparam int CSR_ESTAT  = 'h05;
   localparam int CSR_ERA    = 'h06;
   localparam int CSR_BADV   = 'h07;
   localparam int CSR_EENTRY = 'h0C;
   localparam int CSR_SAVE0  = 'h30;
   localparam int CSR_TCFG   = 'h41;
   localparam int CSR_TVAL   = 'h42;
   localparam int CSR_TICLR  = 'h44;

   localparam int EENTRY_LSB = 6;

   localparam logic [2:0]  MODE_RST = 3'b000;
   localparam logic [12:0] LIE_RST  = 13'h0000;

endpackage

// File: rtl/cpu7_csr_timer.sv
// rtl/cpu7_csr_timer.sv - TCFG/TVAL countdown timer producing a one-cycle expiry pulse
`timescale 1ns/10ps
module cpu7_csr_timer #(
   parameter int GRLEN = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             tcfg_we,
   input  logic [GRLEN-1:0] tcfg_wdata,
   input  logic [GRLEN-1:0] tcfg_wmask,
   output logic [GRLEN-1:0] tcfg,
   output logic [GRLEN-1:0] tval,
   output logic             ti_set
);

   logic [GRLEN-1:0] tcfg_nxt;

   assign tcfg_nxt = (tcfg & ~tcfg_wmask) | (tcfg_wdata & tcfg_wmask);

   // A reload from a TCFG write pre-empts the 1->0 step, so no expiry then
   assign ti_set = !tcfg_we && tcfg[0] && (tval == GRLEN'(1));

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         tcfg <= '0;
         tval <= '0;
      end else if (tcfg_we) begin
         tcfg <= tcfg_nxt;
         tval <= {tcfg_nxt[GRLEN-1:2], 2'b00};
      end else if (tcfg[0]) begin
         if (tval != '0)
            tval <= tval - GRLEN'(1);
         else if (tcfg[1])
            tval <= {tcfg[GRLEN-1:2], 2'b00};
      end
   end

endmodule

// File: rtl/cpu7_csr_excp.sv
// rtl/cpu7_csr_excp.sv - exception/interrupt CSR file; timer CSRs built when CPU7_CSR_TIMER_EN is defined
`timescale 1ns/10ps
module cpu7_csr_excp
   import cpu7_csr_excp_pkg::*;
#(
   parameter int GRLEN    = 32,
   parameter int CSR_BIT  = 14,
   parameter int NUM_SAVE = 4
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic [CSR_BIT-1:0] csr_raddr,
   output logic [GRLEN-1:0]   csr_rdata,
   input  logic [CSR_BIT-1:0] csr_waddr,
   input  logic [GRLEN-1:0]   csr_wdata,
   input  logic [GRLEN-1:0]   csr_wmask,
   input  logic               csr_wen,
   input  logic               excp_valid,
   input  logic [5:0]         excp_ecode,
   input  logic [GRLEN-1:0]   excp_pc,
   input  logic               excp_badv_en,
   input  logic [GRLEN-1:0]   excp_badv,
   input  logic               ertn,
   input  logic [7:0]         hw_int,
   output logic [GRLEN-1:0]   csr_eentry,
   output logic [GRLEN-1:0]   csr_era,
   output logic               int_req
);

   logic [1:0]             crmd_plv, prmd_pplv, is_sw;
   logic                   crmd_ie, prmd_pie, is_ti;
   logic [12:0]            ecfg_lie, is_vec;
   logic [7:0]             is_hw;
   logic [5:0]             ecode;
   logic [GRLEN-1:0]       era, badv, tcfg, tval;
   logic [GRLEN-1:EENTRY_LSB] eentry_hi;
   logic [GRLEN-1:0]       save_q [NUM_SAVE];

   logic we_crmd, we_prmd, we_ecfg, we_estat, we_era, we_badv, we_eentry;
   logic [2:0]  crmd_wr, prmd_wr;
   logic [12:0] lie_wr;
   logic [1:0]  sw_wr;

   assign we_crmd   = csr_wen && (csr_waddr == CSR_BIT'(CSR_CRMD));
   assign we_prmd   = csr_wen && (csr_waddr == CSR_BIT'(CSR_PRMD));
   assign we_ecfg   = csr_wen && (csr_waddr == CSR_BIT'(CSR_ECFG));
   assign we_estat  = csr_wen && (csr_waddr == CSR_BIT'(CSR_ESTAT));
   assign we_era    = csr_wen && (csr_waddr == CSR_BIT'(CSR_ERA));
   assign we_badv   = csr_wen && (csr_waddr == CSR_BIT'(CSR_BADV));
   assign we_eentry = csr_wen && (csr_waddr == CSR_BIT'(CSR_EENTRY));

   assign crmd_wr = ({crmd_ie, crmd_plv} & ~csr_wmask[2:0]) | (csr_wdata[2:0] & csr_wmask[2:0]);
   assign prmd_wr = ({prmd_pie, prmd_pplv} & ~csr_wmask[2:0]) | (csr_wdata[2:0] & csr_wmask[2:0]);
   assign lie_wr  = (ecfg_lie & ~csr_wmask[12:0]) | (csr_wdata[12:0] & csr_wmask[12:0]);
   assign sw_wr   = (is_sw & ~csr_wmask[1:0]) | (csr_wdata[1:0] & csr_wmask[1:0]);

   // Priority per field: exception, then ertn, then software write
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         {crmd_ie, crmd_plv}  <= MODE_RST;
         {prmd_pie, prmd_pplv} <= MODE_RST;
         ecfg_lie  <= LIE_RST;
         is_sw     <= '0;
         is_hw     <= '0;
         ecode     <= '0;
         era       <= '0;
         badv      <= '0;
         eentry_hi <= '0;
      end else begin
         if (excp_valid)
            {crmd_ie, crmd_plv} <= 3'b000;
         else if (ertn)
            {crmd_ie, crmd_plv} <= {prmd_pie, prmd_pplv};
         else if (we_crmd)
            {crmd_ie, crmd_plv} <= crmd_wr;
         if (excp_valid)
            {prmd_pie, prmd_pplv} <= {crmd_ie, crmd_plv};
         else if (we_prmd)
            {prmd_pie, prmd_pplv} <= prmd_wr;
         if (we_ecfg)
            ecfg_lie <= lie_wr;
         if (we_estat)
            is_sw <= sw_wr;
         is_hw <= hw_int;
         if (excp_valid)
            ecode <= excp_ecode;
         if (excp_valid)
            era <= excp_pc;
         else if (we_era)
            era <= (era & ~csr_wmask) | (csr_wdata & csr_wmask);
         if (excp_valid && excp_badv_en)
            badv <= excp_badv;
         else if (we_badv)
            badv <= (badv & ~csr_wmask) | (csr_wdata & csr_wmask);
         if (we_eentry)
            eentry_hi <= (eentry_hi & ~csr_wmask[GRLEN-1:EENTRY_LSB])
                       | (csr_wdata[GRLEN-1:EENTRY_LSB] & csr_wmask[GRLEN-1:EENTRY_LSB]);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < NUM_SAVE; i++) save_q[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_SAVE; i++)
            if (csr_wen && (csr_waddr == CSR_BIT'(CSR_SAVE0 + i)))
               save_q[i] <= (save_q[i] & ~csr_wmask) | (csr_wdata & csr_wmask);
      end
   end

`ifdef CPU7_CSR_TIMER_EN
   logic we_tcfg, ticlr, ti_set;

   assign we_tcfg = csr_wen && (csr_waddr == CSR_BIT'(CSR_TCFG));
   assign ticlr   = csr_wen && (csr_waddr == CSR_BIT'(CSR_TICLR)) && csr_wdata[0] && csr_wmask[0];

   cpu7_csr_timer #(.GRLEN(GRLEN)) u_timer (
      .clk        (clk),
      .resetn     (resetn),
      .tcfg_we    (we_tcfg),
      .tcfg_wdata (csr_wdata),
      .tcfg_wmask (csr_wmask),
      .tcfg       (tcfg),
      .tval       (tval),
      .ti_set     (ti_set)
   );

   // Expiry beats a same-cycle TICLR so a fresh interrupt is never lost
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         is_ti <= 1'b0;
      else if (ti_set)
         is_ti <= 1'b1;
      else if (ticlr)
         is_ti <= 1'b0;
   end
`else
   assign tcfg  = '0;
   assign tval  = '0;
   assign is_ti = 1'b0;
`endif

   assign is_vec     = {1'b0, is_ti, 1'b0, is_hw, is_sw};
   assign int_req    = crmd_ie && |(is_vec & ecfg_lie);
   assign csr_era    = era;
   assign csr_eentry = {eentry_hi, {EENTRY_LSB{1'b0}}};

   always_comb begin
      csr_rdata = '0;
      case (csr_raddr)
         CSR_BIT'(CSR_CRMD):   csr_rdata = GRLEN'({crmd_ie, crmd_plv});
         CSR_BIT'(CSR_PRMD):   csr_rdata = GRLEN'({prmd_pie, prmd_pplv});
         CSR_BIT'(CSR_ECFG):   csr_rdata = GRLEN'(ecfg_lie);
         CSR_BIT'(CSR_ESTAT):  csr_rdata = GRLEN'({ecode, 3'b000, is_vec});
         CSR_BIT'(CSR_ERA):    csr_rdata = era;
         CSR_BIT'(CSR_BADV):   csr_rdata = badv;
         CSR_BIT'(CSR_EENTRY): csr_rdata = csr_eentry;
         CSR_BIT'(CSR_TCFG):   csr_rdata = tcfg;
         CSR_BIT'(CSR_TVAL):   csr_rdata = tval;
         default:              csr_rdata = '0;
      endcase
      for (int i = 0; i < NUM_SAVE; i++)
         if (csr_raddr == CSR_BIT'(CSR_SAVE0 + i))
            csr_rdata = save_q[i];
   end

endmodule

// File: tb/tb_cpu7_csr_excp.sv
// tb/tb_cpu7_csr_excp.sv - directed and random checks of cpu7_csr_excp against a register-image model
`timescale 1ns/10ps
module tb_cpu7_csr_excp;

   localparam int GRLEN = 32, CSR_BIT = 14, NUM_SAVE = 4;
`ifdef CPU7_CSR_TIMER_EN
   localparam bit TMR = 1'b1;
`else
   localparam bit TMR = 1'b0;
`endif

   logic               clk, resetn;
   logic [CSR_BIT-1:0] csr_raddr, csr_waddr;
   logic [GRLEN-1:0]   csr_rdata, csr_wdata, csr_wmask;
   logic               csr_wen, excp_valid, excp_badv_en, ertn, int_req;
   logic [5:0]         excp_ecode;
   logic [GRLEN-1:0]   excp_pc, excp_badv, csr_eentry, csr_era;
   logic [7:0]         hw_int;

   cpu7_csr_excp #(.GRLEN(GRLEN), .CSR_BIT(CSR_BIT), .NUM_SAVE(NUM_SAVE)) dut (
      .clk(clk), .resetn(resetn),
      .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
      .csr_waddr(csr_waddr), .csr_wdata(csr_wdata), .csr_wmask(csr_wmask), .csr_wen(csr_wen),
      .excp_valid(excp_valid), .excp_ecode(excp_ecode), .excp_pc(excp_pc),
      .excp_badv_en(excp_badv_en), .excp_badv(excp_badv),
      .ertn(ertn), .hw_int(hw_int),
      .csr_eentry(csr_eentry), .csr_era(csr_era), .int_req(int_req)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0, n_err = 0;

   logic [31:0] m_crmd, m_prmd, m_ecfg, m_estat, m_era, m_badv, m_eentry, m_tcfg, m_tval;
   logic [31:0] m_save [NUM_SAVE];
   int addrs [17] = '{'h0, 'h1, 'h4, 'h5, 'h6, 'h7, 'hC, 'h30, 'h31, 'h32, 'h33,
                      'h34, 'h41, 'h42, 'h44, 'h2, 'h3FFF};

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      {m_crmd, m_prmd, m_ecfg, m_estat, m_era, m_badv, m_eentry, m_tcfg, m_tval} = '0;
      for (int i = 0; i < NUM_SAVE; i++) m_save[i] = '0;
   endtask

   function automatic logic [31:0] writable(input int a);
      if (a == 'h0 || a == 'h1) return 32'h7;
      if (a == 'h4) return 32'h1FFF;
      if (a == 'h5) return 32'h3;
      if (a == 'h6 || a == 'h7) return 32'hFFFF_FFFF;
      if (a == 'hC) return 32'hFFFF_FFC0;
      if (a >= 'h30 && a < 'h30 + NUM_SAVE) return 32'hFFFF_FFFF;
      if (a == 'h41 && TMR) return 32'hFFFF_FFFF;
      return 32'h0;
   endfunction

   function automatic logic [31:0] model_rd(input int a);
      if (a == 'h0) return m_crmd;
      if (a == 'h1) return m_prmd;
      if (a == 'h4) return m_ecfg;
      if (a == 'h5) return m_estat;
      if (a == 'h6) return m_era;
      if (a == 'h7) return m_badv;
      if (a == 'hC) return m_eentry;
      if (a >= 'h30 && a < 'h30 + NUM_SAVE) return m_save[a - 'h30];
      if (a == 'h41) return m_tcfg;
      if (a == 'h42) return m_tval;
      return 32'h0;
   endfunction

   // Advance one clock: compute the model's next state from the inputs now applied
   task automatic tick();
      logic [31:0] n_crmd, n_prmd, n_ecfg, n_estat, n_era, n_badv, n_eentry, n_tcfg, n_tval, m, wv;
      logic [31:0] n_save [NUM_SAVE];
      int a;
      bit tset, tclr;
      n_crmd = m_crmd; n_prmd = m_prmd; n_ecfg = m_ecfg; n_estat = m_estat; n_era = m_era;
      n_badv = m_badv; n_eentry = m_eentry; n_tcfg = m_tcfg; n_tval = m_tval;
      for (int i = 0; i < NUM_SAVE; i++) n_save[i] = m_save[i];
      a = int'(csr_waddr);
      m = csr_wmask & writable(a);
      wv = (model_rd(a) & ~m) | (csr_wdata & m);
      tset = 0;
      tclr = TMR && csr_wen && a == 'h44 && csr_wdata[0] && csr_wmask[0];
      if (csr_wen) begin
         if (a == 'h0) n_crmd = wv;
         if (a == 'h1) n_prmd = wv;
         if (a == 'h4) n_ecfg = wv;
         if (a == 'h5) n_estat = wv;
         if (a == 'h6) n_era = wv;
         if (a == 'h7) n_badv = wv;
         if (a == 'hC) n_eentry = wv;
         if (a >= 'h30 && a < 'h30 + NUM_SAVE) n_save[a - 'h30] = wv;
      end
      if (TMR) begin
         if (csr_wen && a == 'h41) begin
            n_tcfg = wv;
            n_tval = wv & 32'hFFFF_FFFC;
         end else if (m_tcfg[0]) begin
            if (m_tval != 0) begin
               n_tval = m_tval - 1;
               tset = (m_tval == 1);
            end else if (m_tcfg[1]) n_tval = m_tcfg & 32'hFFFF_FFFC;
         end
      end
      n_estat[9:2] = hw_int;
      if (tset) n_estat[11] = 1'b1;
      else if (tclr) n_estat[11] = 1'b0;
      if (ertn && !excp_valid) n_crmd[2:0] = m_prmd[2:0];
      if (excp_valid) begin
         n_prmd[2:0] = m_crmd[2:0];
         n_crmd[2:0] = 3'b000;
         n_era = excp_pc;
         n_estat[21:16] = excp_ecode;
         if (excp_badv_en) n_badv = excp_badv;
      end
      @(posedge clk);
      m_crmd = n_crmd; m_prmd = n_prmd; m_ecfg = n_ecfg; m_estat = n_estat; m_era = n_era;
      m_badv = n_badv; m_eentry = n_eentry; m_tcfg = n_tcfg; m_tval = n_tval;
      for (int i = 0; i < NUM_SAVE; i++) m_save[i] = n_save[i];
      #1;
      csr_wen = 0; excp_valid = 0; ertn = 0; excp_badv_en = 0;
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".int_req"}, int_req, m_crmd[2] & |(m_estat[12:0] & m_ecfg[12:0]));
      chk({tag, ".era"}, csr_era, m_era);
      chk({tag, ".eentry"}, csr_eentry, m_eentry);
      foreach (addrs[i]) begin
         csr_raddr = CSR_BIT'(addrs[i]);
         #0.1;
         chk($sformatf("%s.rd%0h", tag, addrs[i]), csr_rdata, model_rd(addrs[i]));
      end
   endtask

   task automatic rd_lit(input string tag, input int a, input int lsb, input int w, input logic [31:0] exp);
      logic [31:0] v;
      csr_raddr = CSR_BIT'(a);
      #0.1;
      v = (csr_rdata >> lsb) & ((32'h1 << w) - 1);
      chk(tag, v, exp);
   endtask

   task automatic wr(input int a, input logic [31:0] d, input logic [31:0] m);
      csr_wen = 1; csr_waddr = CSR_BIT'(a); csr_wdata = d; csr_wmask = m;
   endtask

   initial begin
      resetn = 0; csr_raddr = '0; csr_waddr = '0; csr_wdata = '0; csr_wmask = '0; csr_wen = 0;
      excp_valid = 0; excp_ecode = '0; excp_pc = '0; excp_badv_en = 0; excp_badv = '0;
      ertn = 0; hw_int = '0;
      model_reset();
      #12;
      check_all("reset");
      @(negedge clk);
      resetn = 1;

      // Exception in the first cycle after reset release
      excp_valid = 1; excp_ecode = 6'h01; excp_pc = 32'h1000_0040;
      tick();
      rd_lit("first_excp_era", 'h6, 0, 32, 32'h1000_0040);
      check_all("first_excp");

      wr('h0, 32'h7, 32'hFFFF_FFFF);
      tick();
      rd_lit("crmd_write", 'h0, 0, 32, 32'h7);
      excp_valid = 1; excp_ecode = 6'h09; excp_pc = 32'h1C00_0100;
      tick();
      rd_lit("excp_crmd", 'h0, 0, 32, 32'h0);
      rd_lit("excp_prmd", 'h1, 0, 32, 32'h7);
      rd_lit("excp_era", 'h6, 0, 32, 32'h1C00_0100);
      rd_lit("excp_ecode", 'h5, 16, 6, 32'h09);
      chk("excp_era_port", csr_era, 32'h1C00_0100);
      check_all("excp");

      ertn = 1;
      tick();
      rd_lit("ertn_crmd", 'h0, 0, 32, 32'h7);
      rd_lit("ertn_prmd", 'h1, 0, 32, 32'h7);

      excp_valid = 1; ertn = 1; excp_ecode = 6'h0A; excp_pc = 32'h1C00_0200;
      wr('h0, 32'h3, 32'hFFFF_FFFF);
      tick();
      rd_lit("collide_crmd", 'h0, 0, 32, 32'h0);
      excp_valid = 1; ertn = 1; excp_pc = 32'h1C00_0300;
      wr('h31, 32'hA5, 32'hFFFF_FFFF);
      tick();
      rd_lit("collide_save1", 'h31, 0, 32, 32'hA5);
      check_all("collide");

      wr('hC, 32'h1C00_8FFF, 32'hFFFF_FFFF);
      tick();
      chk("eentry_low_zero", csr_eentry, 32'h1C00_8FC0);

      wr('h4, 32'h004, 32'hFFFF_FFFF);
      tick();
      wr('h0, 32'h4, 32'hFFFF_FFFF);
      tick();
      hw_int = 8'h01;
      tick();
      chk("int_req_on", int_req, 1'b1);
      hw_int = 8'h00;
      tick();
      chk("int_req_off", int_req, 1'b0);
      check_all("int");

      wr('h41, 32'h13, 32'hFFFF_FFFF);
      tick();
      if (TMR) begin
         rd_lit("tval_load", 'h42, 0, 32, 32'h10);
         for (int i = 0; i < 15; i++) tick();
         rd_lit("tval_one", 'h42, 0, 32, 32'h1);
         tick();
         rd_lit("tval_zero", 'h42, 0, 32, 32'h0);
         rd_lit("ti_set", 'h5, 11, 1, 32'h1);
         tick();
         rd_lit("tval_reload", 'h42, 0, 32, 32'h10);
         wr('h44, 32'h1, 32'hFFFF_FFFF);
         tick();
         rd_lit("ti_clear", 'h5, 11, 1, 32'h0);
         wr('h41, 32'h11, 32'hFFFF_FFFF);
         tick();
         for (int i = 0; i < 16; i++) tick();
         rd_lit("oneshot_ti", 'h5, 11, 1, 32'h1);
         tick();
         rd_lit("oneshot_hold", 'h42, 0, 32, 32'h0);
         check_all("timer");
      end else begin
         rd_lit("no_timer_tcfg", 'h41, 0, 32, 32'h0);
         rd_lit("no_timer_tval", 'h42, 0, 32, 32'h0);
      end

      for (int c = 0; c < 300; c++) begin
         if ($urandom_range(0, 2) != 0) begin
            int pick;
            pick = addrs[$urandom_range(0, 16)];
            wr(pick, $urandom, ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : $urandom);
            if (pick == 'h41) csr_wdata = csr_wdata & 32'h0000_007F;
         end
         excp_valid = ($urandom_range(0, 5) == 0);
         ertn = ($urandom_range(0, 5) == 0);
         excp_ecode = 6'($urandom);
         excp_pc = $urandom;
         excp_badv_en = $urandom_range(0, 1) != 0;
         excp_badv = $urandom;
         if ($urandom_range(0, 3) == 0) hw_int = 8'($urandom);
         tick();
         check_all($sformatf("rand%0d", c));
      end

      // Reset asserted mid-cycle with interrupt active, timer running and an exception pending
      wr('h4, 32'h1FFF, 32'hFFFF_FFFF);
      tick();
      wr('h0, 32'h4, 32'hFFFF_FFFF);
      hw_int = 8'hFF;
      tick();
      wr('h41, 32'h13, 32'hFFFF_FFFF);
      tick();
      tick();
      chk("pre_reset_int", int_req, 1'b1);
      excp_valid = 1; excp_ecode = 6'h3F; excp_pc = 32'hDEAD_BEE0;
      #2;
      resetn = 0;
      model_reset();
      #0.5;
      chk("async_int_req", int_req, 1'b0);
      check_all("async_reset");
      excp_valid = 0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
